// File: rtl/gmsk_burst_feeder_if.sv
// Byte-side handshake and modulator-side strobe/bit bundle of the GMSK burst feeder.
// slave = feeder side, master = byte source / modulator side.
interface gmsk_burst_feeder_if;
  logic       burst_start;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       burst_busy;
  logic       underrun;
  logic       sample_strobe;
  logic       symbol_strobe;
  logic       tx_bit;

  modport slave (
    input  burst_start, data_in, data_valid,
    output data_ready, burst_busy, underrun, sample_strobe, symbol_strobe, tx_bit
  );

  modport master (
    output burst_start, data_in, data_valid,
    input  data_ready, burst_busy, underrun, sample_strobe, symbol_strobe, tx_bit
  );
endinterface

// File: rtl/gmsk_burst_feeder.sv
// Frames head tail / payload / end tail / guard into one bit per symbol with free-running strobes.
// Bytes enter via valid/ready into a 1-byte holding reg; DIFF_ENCODE_EN adds GSM differential encoding.
module gmsk_burst_feeder #(
  parameter int                  SAMPLES_PER_SYMBOL = 128,
  parameter int                  ACC_BITS           = 24,
  parameter logic [ACC_BITS-1:0] SAMPLE_INC         = 24'h2A_AAAB,
  parameter int                  TAIL_BITS          = 3,
  parameter int                  PAYLOAD_BITS       = 142,
  parameter int                  GUARD_SYMBOLS      = 8
) (
  input logic clock,
  input logic reset,
  gmsk_burst_feeder_if.slave bus
);

  localparam int SCW   = (SAMPLES_PER_SYMBOL > 1) ? $clog2(SAMPLES_PER_SYMBOL) : 1;
  localparam int BYTES = (PAYLOAD_BITS + 7) / 8;
  localparam int BLW   = $clog2(BYTES + 1);

  localparam logic [SCW-1:0] SC_LAST    = SCW'(SAMPLES_PER_SYMBOL - 1);
  localparam logic [7:0]     TAIL_LAST  = 8'(TAIL_BITS - 1);
  localparam logic [7:0]     PAY_LAST   = 8'(PAYLOAD_BITS - 1);
  localparam logic [7:0]     GUARD_END  = 8'(GUARD_SYMBOLS);
  localparam logic [BLW-1:0] BYTES_INIT = BLW'(BYTES);

  typedef enum logic [2:0] {IDLE, HEAD, PAYLOAD, TAIL, GUARD} state_t;

  state_t              state;
  logic [ACC_BITS-1:0] acc;
  logic [SCW-1:0]      sample_cnt;
  logic [7:0]          sym_cnt;
  logic [7:0]          shift_reg;
  logic [3:0]          shift_cnt;
  logic [7:0]          hold_reg;
  logic                hold_full;
  logic [BLW-1:0]      bytes_left;

  logic [ACC_BITS:0]   acc_sum;
  logic                sym_tick;
  logic                take;
  logic                load_hold;
  logic [7:0]          eff_sh;
  logic [3:0]          eff_cnt;
  logic                d_bit;
  logic                tx_next;

  assign acc_sum  = {1'b0, acc} + {1'b0, SAMPLE_INC};
  // Boundary edge: the sample strobe that wraps sample_cnt; symbol_strobe lands one clock later.
  assign sym_tick = bus.sample_strobe && (sample_cnt == SC_LAST);

  assign bus.data_ready = !hold_full && (state == HEAD || state == PAYLOAD) && (bytes_left != '0);
  assign take           = bus.data_valid && bus.data_ready;

  // An empty shift reg pulls the holding byte in, so a byte arriving just before a boundary is used.
  assign load_hold = (shift_cnt == 4'd0) && hold_full;
  assign eff_sh    = load_hold ? hold_reg : shift_reg;
  assign eff_cnt   = load_hold ? 4'd8 : shift_cnt;
  assign d_bit     = (state == PAYLOAD) && (eff_cnt != 4'd0) && eff_sh[0];

`ifdef DIFF_ENCODE_EN
  logic d_prev;
  assign tx_next = d_bit ^ d_prev;
`else
  assign tx_next = d_bit;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      acc               <= '0;
      sample_cnt        <= '0;
      sym_cnt           <= '0;
      shift_reg         <= '0;
      shift_cnt         <= '0;
      hold_reg          <= '0;
      hold_full         <= 1'b0;
      bytes_left        <= '0;
      bus.sample_strobe <= 1'b0;
      bus.symbol_strobe <= 1'b0;
      bus.tx_bit        <= 1'b0;
      bus.underrun      <= 1'b0;
      bus.burst_busy    <= 1'b0;
`ifdef DIFF_ENCODE_EN
      d_prev            <= 1'b1;
`endif
    end else begin
      acc               <= acc_sum[ACC_BITS-1:0];
      bus.sample_strobe <= acc_sum[ACC_BITS];
      bus.symbol_strobe <= sym_tick;
      bus.underrun      <= 1'b0;

      if (bus.sample_strobe)
        sample_cnt <= (sample_cnt == SC_LAST) ? '0 : sample_cnt + 1'b1;

      if (take) begin
        hold_reg   <= bus.data_in;
        hold_full  <= 1'b1;
        bytes_left <= bytes_left - 1'b1;
      end else if (load_hold) begin
        hold_full  <= 1'b0;
      end

      shift_reg <= eff_sh;
      shift_cnt <= eff_cnt;

      if (sym_tick) begin
        bus.tx_bit <= tx_next;
`ifdef DIFF_ENCODE_EN
        d_prev     <= d_bit;
`endif
        case (state)
          HEAD: begin
            if (sym_cnt == TAIL_LAST) begin
              state   <= PAYLOAD;
              sym_cnt <= '0;
            end else begin
              sym_cnt <= sym_cnt + 1'b1;
            end
          end
          PAYLOAD: begin
            // Underrun still consumes a payload slot so the burst length never changes.
            if (eff_cnt == 4'd0) begin
              bus.underrun <= 1'b1;
            end else begin
              shift_reg <= {1'b0, eff_sh[7:1]};
              shift_cnt <= eff_cnt - 1'b1;
            end
            if (sym_cnt == PAY_LAST) begin
              state   <= TAIL;
              sym_cnt <= '0;
            end else begin
              sym_cnt <= sym_cnt + 1'b1;
            end
          end
          TAIL: begin
            if (sym_cnt == TAIL_LAST) begin
              state   <= GUARD;
              sym_cnt <= '0;
            end else begin
              sym_cnt <= sym_cnt + 1'b1;
            end
          end
          GUARD: begin
            // The boundary after the last guard symbol already emits idle and drops busy.
            if (sym_cnt == GUARD_END) begin
              state          <= IDLE;
              bus.burst_busy <= 1'b0;
              sym_cnt        <= '0;
            end else begin
              sym_cnt <= sym_cnt + 1'b1;
            end
          end
          default: ;
        endcase
      end

      if (state == IDLE && bus.burst_start) begin
        state          <= HEAD;
        bus.burst_busy <= 1'b1;
        sym_cnt        <= '0;
        shift_cnt      <= '0;
        hold_full      <= 1'b0;
        bytes_left     <= BYTES_INIT;
`ifdef DIFF_ENCODE_EN
        d_prev         <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: tb/tb_gmsk_burst_feeder.sv
// Directed bench for gmsk_burst_feeder: strobe timing, full bursts, underrun, ignored start, async reset.
// Runs with 8 samples/symbol and a quarter-range increment so a symbol is 32 clocks.
module tb_gmsk_burst_feeder;

  localparam int          SPS   = 8;
  localparam logic [23:0] INC   = 24'h40_0000;
  localparam int          NSYM  = 156;
  localparam int          NBYTE = 24;

  logic clock = 1'b0;
  logic reset = 1'b1;

  gmsk_burst_feeder_if bus();

  gmsk_burst_feeder #(
    .SAMPLES_PER_SYMBOL(SPS),
    .ACC_BITS          (24),
    .SAMPLE_INC        (INC),
    .TAIL_BITS         (3),
    .PAYLOAD_BITS      (142),
    .GUARD_SYMBOLS     (8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [7:0] bytes [NBYTE];
  logic       exp_tx [NSYM];
  logic       exp_ur [NSYM];
  logic       log_tx [$];
  logic       log_ur [$];

  int burst_syms, accepted, byte_idx, tick_n, first_log, wh_idx, wh_until;
  bit fire, feed_en, log_en, ended;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock step: observe outputs at the falling edge, then update the byte source.
  task automatic tick();
    @(negedge clock);
    tick_n++;
    if (bus.symbol_strobe && log_en) begin
      if (bus.burst_busy) begin
        if (burst_syms == 0) first_log = tick_n;
        log_tx.push_back(bus.tx_bit);
        log_ur.push_back(bus.underrun);
        burst_syms++;
      end else if (burst_syms > 0) begin
        ended = 1'b1;
      end
    end
    if (fire) begin
      accepted++;
      byte_idx++;
    end
    bus.data_in    = (byte_idx < NBYTE) ? bytes[byte_idx] : 8'h00;
    bus.data_valid = feed_en && (byte_idx < NBYTE) && !(byte_idx == wh_idx && burst_syms < wh_until);
    fire           = bus.data_valid && bus.data_ready;
  endtask

  task automatic build_model(input int ur_from, input int ur_len);
    int  bi;
    int  p;
    logic d;
`ifdef DIFF_ENCODE_EN
    logic prev;
    prev = 1'b1;
`endif
    bi = 0;
    for (int n = 0; n < NSYM; n++) begin
      d         = 1'b0;
      exp_ur[n] = 1'b0;
      if (n >= 3 && n < 145) begin
        p = n - 3;
        if (p >= ur_from && p < ur_from + ur_len) begin
          exp_ur[n] = 1'b1;
        end else begin
          d = bytes[bi / 8][bi % 8];
          bi++;
        end
      end
`ifdef DIFF_ENCODE_EN
      exp_tx[n] = d ^ prev;
      prev      = d;
`else
      exp_tx[n] = d;
`endif
    end
  endtask

  task automatic run_burst(input int align, input int ign_at, input int abort_at);
    int  n;
    bit  ign_done;
    log_tx.delete();
    log_ur.delete();
    burst_syms = 0;
    accepted   = 0;
    byte_idx   = 0;
    first_log  = 0;
    fire       = 1'b0;
    ended      = 1'b0;
    log_en     = 1'b0;
    feed_en    = 1'b1;
    ign_done   = 1'b0;
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.symbol_strobe && n < 100);
    check("align_strobe", bus.symbol_strobe, 1);
    repeat (align) tick();
    bus.burst_start = 1'b1;
    tick_n = 0;
    tick();
    bus.burst_start = 1'b0;
    log_en = 1'b1;
    n = 0;
    while (!ended && n < 6000 && !(abort_at > 0 && burst_syms >= abort_at)) begin
      if (ign_at > 0 && burst_syms == ign_at && !ign_done) begin
        bus.burst_start = 1'b1;
        tick();
        bus.burst_start = 1'b0;
        ign_done = 1'b1;
      end else begin
        tick();
      end
      n++;
    end
    if (abort_at == 0) check("burst_end", ended, 1);
    feed_en        = 1'b0;
    bus.data_valid = 1'b0;
    log_en         = 1'b0;
  endtask

  task automatic compare_burst(input int exp_acc, input int exp_first);
    check("busy_syms", burst_syms, NSYM);
    check("bytes_acc", accepted, exp_acc);
    check("head_latency", first_log, exp_first);
    for (int i = 0; i < NSYM && i < burst_syms; i++) begin
      check($sformatf("tx_%0d", i), log_tx[i], exp_tx[i]);
      check($sformatf("ur_%0d", i), log_ur[i], exp_ur[i]);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_sample"}, bus.sample_strobe, 0);
    check({tag, "_symbol"}, bus.symbol_strobe, 0);
    check({tag, "_tx"},     bus.tx_bit, 0);
    check({tag, "_busy"},   bus.burst_busy, 0);
    check({tag, "_under"},  bus.underrun, 0);
    check({tag, "_ready"},  bus.data_ready, 0);
  endtask

  // Counts from the clock after reset release.
  task automatic check_timing(input int nticks);
    int last_ss, last_sym, ss_since, ss_bad, sym_bad, coinc, after_bad, nsym, first_ss, first_sym;
    bit prev_ss;
    last_ss = 0; last_sym = 0; ss_since = 0; ss_bad = 0; sym_bad = 0; coinc = 0;
    after_bad = 0; nsym = 0; first_ss = 0; first_sym = 0; prev_ss = 1'b0;
    for (int t = 1; t <= nticks; t++) begin
      tick();
      if (bus.sample_strobe) begin
        if (first_ss == 0) first_ss = t;
        if (last_ss > 0 && t - last_ss != 4) ss_bad++;
        last_ss = t;
        ss_since++;
      end
      if (bus.symbol_strobe) begin
        if (first_sym == 0) first_sym = t;
        if (bus.sample_strobe) coinc++;
        if (!prev_ss || ss_since != SPS) after_bad++;
        if (last_sym > 0 && t - last_sym != 32) sym_bad++;
        last_sym = t;
        ss_since = 0;
        nsym++;
      end
      prev_ss = bus.sample_strobe;
    end
    check("first_sample", first_ss, 4);
    check("first_symbol", first_sym, 33);
    check("sample_period", ss_bad, 0);
    check("symbol_period", sym_bad, 0);
    check("coincident", coinc, 0);
    check("symbol_after_sample", after_bad, 0);
    check("symbol_count", nsym, 40);
  endtask

  initial begin
    int  n, first_ss, first_sym, busy_seen;
    logic sym_tx, sym_busy, idle_tx;
`ifdef DIFF_ENCODE_EN
    idle_tx = 1'b1;
`else
    idle_tx = 1'b0;
`endif
    bus.burst_start = 1'b0;
    bus.data_valid  = 1'b0;
    bus.data_in     = 8'h00;
    feed_en = 1'b0; log_en = 1'b0; fire = 1'b0; ended = 1'b0;
    wh_idx = -1; wh_until = 0; byte_idx = 0; tick_n = 0; burst_syms = 0; accepted = 0;

    repeat (3) @(negedge clock);
    check_outputs_zero("reset");
    reset = 1'b0;
    check_timing(1300);

    // Full burst of A5 bytes
    for (int i = 0; i < NBYTE; i++) bytes[i] = 8'hA5;
    build_model(0, 0);
    run_burst(0, 0, 0);
    compare_burst(18, 32);

    // Fifth byte withheld until payload symbol 51 has gone out
    for (int i = 0; i < NBYTE; i++) bytes[i] = 8'(i * 37 + 11);
    wh_idx = 4;
    wh_until = 55;
    build_model(32, 20);
    run_burst(0, 0, 0);
    compare_burst(17, 32);
    wh_idx = -1;

    // burst_start during payload must not restart or queue a burst
    for (int i = 0; i < NBYTE; i++) bytes[i] = 8'hA5;
    build_model(0, 0);
    run_burst(0, 80, 0);
    compare_burst(18, 32);
    busy_seen = 0;
    repeat (3 * 32) begin
      tick();
      if (bus.symbol_strobe && bus.burst_busy) busy_seen++;
    end
    check("no_queued_burst", busy_seen, 0);

    // Start coincident with a boundary: head begins one boundary later
    for (int i = 0; i < NBYTE; i++) bytes[i] = 8'hFF;
    build_model(0, 0);
    run_burst(31, 0, 0);
    compare_burst(18, 33);

    // Reset after payload symbol 60
    for (int i = 0; i < NBYTE; i++) bytes[i] = 8'hA5;
    run_burst(0, 0, 64);
    check("busy_before_reset", bus.burst_busy, 1);
    #1 reset = 1'b1;
    #1 check_outputs_zero("async_reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;
    n = 0; first_ss = 0; first_sym = 0; sym_tx = 1'b0; sym_busy = 1'b1;
    while (first_sym == 0 && n < 200) begin
      tick();
      n++;
      if (bus.sample_strobe && first_ss == 0) first_ss = n;
      if (bus.symbol_strobe) begin
        first_sym = n;
        sym_tx    = bus.tx_bit;
        sym_busy  = bus.burst_busy;
      end
    end
    check("post_reset_sample", first_ss, 4);
    check("post_reset_symbol", first_sym, 33);
    check("post_reset_busy", sym_busy, 0);
    check("post_reset_idle_tx", sym_tx, idle_tx);
    check("post_reset_ready", bus.data_ready, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
